// File: rtl/rpn_stack_sequencer.sv
// Postfix token sequencer: expands RPN tokens into one-cycle commands for a combinational stack ALU.
// Optional macro RPN_SATURATE_EN: push a saturated result when the arithmetic step overflows.
module rpn_stack_sequencer #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tok_valid,
  output logic                tok_ready,
  input  logic                tok_is_op,
  input  logic                tok_op,
  input  logic signed [N-1:0] tok_value,
  input  logic                tok_last,
  output logic [2:0]          alu_opcode,
  output logic signed [N-1:0] alu_data,
  input  logic signed [N-1:0] alu_result,
  input  logic                alu_overflow,
  output logic                res_valid,
  output logic signed [N-1:0] res_data,
  output logic                res_overflow,
  output logic                err_underflow,
  output logic                err_full,
  output logic                busy
);
  localparam int DW = $clog2(N + 1);
  localparam logic [DW-1:0] DEPTH_MAX  = DW'(N);
  localparam logic [DW-1:0] FLUSH_LAST = DW'(N - 1);
`ifdef RPN_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_ADD  = 3'b100;
  localparam logic [2:0] OPC_MUL  = 3'b101;
  localparam logic [2:0] OPC_PUSH = 3'b110;
  localparam logic [2:0] OPC_POP  = 3'b111;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_GAP, S_POPB, S_POPA, S_PUSHR, S_FINAL, S_DRAIN
  } state_t;

  state_t              state, state_nxt, ret, ret_nxt;
  logic [DW-1:0]       depth, depth_nxt, fcnt, fcnt_nxt;
  logic                ovf_acc, ovf_acc_nxt, op_mul, op_mul_nxt, op_ovf, op_ovf_nxt;
  logic                last_q, last_nxt;
  logic                res_load, res_ovf_nxt, res_valid_nxt, err_u_nxt, err_f_nxt;
  logic signed [N-1:0] res_data_nxt, push_val;
  logic                cap_r, cap_a, cap_b;
  logic signed [N-1:0] r_q, a_q, b_q;

  function automatic logic signed [N-1:0] sat_value(input logic is_mul,
                                                    input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
    logic neg;
    neg = is_mul ? (a[N-1] ^ b[N-1]) : a[N-1];
    return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  assign push_val = (SAT_EN && op_ovf) ? sat_value(op_mul, a_q, b_q) : r_q;

  // Every command cycle is followed by a GAP (NOP) that resumes at ret.
  always_comb begin
    state_nxt     = state;
    ret_nxt       = ret;
    depth_nxt     = depth;
    fcnt_nxt      = fcnt;
    ovf_acc_nxt   = ovf_acc;
    op_mul_nxt    = op_mul;
    op_ovf_nxt    = op_ovf;
    last_nxt      = last_q;
    res_load      = 1'b0;
    res_data_nxt  = '0;
    res_ovf_nxt   = res_overflow;
    res_valid_nxt = 1'b0;
    err_u_nxt     = 1'b0;
    err_f_nxt     = 1'b0;
    cap_r         = 1'b0;
    cap_a         = 1'b0;
    cap_b         = 1'b0;
    alu_opcode    = OPC_NOP;
    alu_data      = '0;
    tok_ready     = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_FLUSH: begin
          alu_opcode = OPC_POP;
          fcnt_nxt   = fcnt + 1'b1;
          ret_nxt    = (fcnt == FLUSH_LAST) ? S_IDLE : S_FLUSH;
          state_nxt  = S_GAP;
        end
        S_IDLE: begin
          tok_ready = 1'b1;
          if (tok_valid) begin
            if (!tok_is_op) begin
              if (depth == DEPTH_MAX) begin
                err_f_nxt = 1'b1;
                state_nxt = tok_last ? S_FINAL : S_IDLE;
              end else begin
                alu_opcode = OPC_PUSH;
                alu_data   = tok_value;
                depth_nxt  = depth + 1'b1;
                ret_nxt    = tok_last ? S_FINAL : S_IDLE;
                state_nxt  = S_GAP;
              end
            end else if (depth < DW'(2)) begin
              err_u_nxt = 1'b1;
              state_nxt = tok_last ? S_FINAL : S_IDLE;
            end else begin
              alu_opcode  = tok_op ? OPC_MUL : OPC_ADD;
              cap_r       = 1'b1;
              ovf_acc_nxt = ovf_acc | alu_overflow;
              op_mul_nxt  = tok_op;
              op_ovf_nxt  = alu_overflow;
              last_nxt    = tok_last;
              ret_nxt     = S_POPB;
              state_nxt   = S_GAP;
            end
          end
        end
        S_GAP: state_nxt = ret;
        S_POPB: begin
          alu_opcode = OPC_POP;
          cap_b      = 1'b1;
          depth_nxt  = depth - 1'b1;
          ret_nxt    = S_POPA;
          state_nxt  = S_GAP;
        end
        S_POPA: begin
          alu_opcode = OPC_POP;
          cap_a      = 1'b1;
          depth_nxt  = depth - 1'b1;
          ret_nxt    = S_PUSHR;
          state_nxt  = S_GAP;
        end
        S_PUSHR: begin
          alu_opcode = OPC_PUSH;
          alu_data   = push_val;
          depth_nxt  = depth + 1'b1;
          ret_nxt    = last_q ? S_FINAL : S_IDLE;
          state_nxt  = S_GAP;
        end
        S_FINAL: begin
          res_load      = 1'b1;
          res_valid_nxt = 1'b1;
          res_ovf_nxt   = ovf_acc;
          ovf_acc_nxt   = 1'b0;
          if (depth == '0) begin
            err_u_nxt = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            alu_opcode   = OPC_POP;
            res_data_nxt = alu_result;
            depth_nxt    = depth - 1'b1;
            ret_nxt      = (depth == DW'(1)) ? S_IDLE : S_DRAIN;
            state_nxt    = S_GAP;
          end
        end
        S_DRAIN: begin
          alu_opcode = OPC_POP;
          depth_nxt  = depth - 1'b1;
          ret_nxt    = (depth == DW'(1)) ? S_IDLE : S_DRAIN;
          state_nxt  = S_GAP;
        end
        default: state_nxt = S_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FLUSH;
      ret           <= S_FLUSH;
      depth         <= '0;
      fcnt          <= '0;
      ovf_acc       <= 1'b0;
      op_mul        <= 1'b0;
      op_ovf        <= 1'b0;
      last_q        <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_full      <= 1'b0;
    end else begin
      state         <= state_nxt;
      ret           <= ret_nxt;
      depth         <= depth_nxt;
      fcnt          <= fcnt_nxt;
      ovf_acc       <= ovf_acc_nxt;
      op_mul        <= op_mul_nxt;
      op_ovf        <= op_ovf_nxt;
      last_q        <= last_nxt;
      res_valid     <= res_valid_nxt;
      err_underflow <= err_u_nxt;
      err_full      <= err_f_nxt;
      if (res_load) begin
        res_data     <= res_data_nxt;
        res_overflow <= res_ovf_nxt;
      end
    end
  end

  // Operand capture registers: datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (cap_r) r_q <= alu_result;
    if (cap_a) a_q <= alu_result;
    if (cap_b) b_q <= alu_result;
  end
endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer: behavioural stack ALU plus a result scoreboard.
module tb_rpn_stack_sequencer;
  localparam int N = 8;
  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b110, POP = 3'b111;
  localparam logic [2:0] ADD = 3'b100, MUL = 3'b101;
`ifdef RPN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic tok_valid = 1'b0, tok_is_op = 1'b0, tok_op = 1'b0, tok_last = 1'b0;
  logic signed [N-1:0] tok_value = '0;
  logic tok_ready, alu_overflow, res_valid, res_overflow, err_underflow, err_full, busy;
  logic [2:0] alu_opcode;
  logic signed [N-1:0] alu_data, alu_result, res_data;

  int n_assert = 0, n_fail = 0;
  int n_full = 0, n_uf = 0, n_res = 0, n_push = 0;
  typedef struct { int d; bit o; bit u; } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  logic signed [N-1:0] stk [0:N-1] = '{default: 8'sh5A};
  int sp = 3;
  int alu_top, alu_nxt, alu_full;

  always #5 clk = ~clk;

  rpn_stack_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_op(tok_op), .tok_value(tok_value), .tok_last(tok_last),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .res_valid(res_valid), .res_data(res_data),
    .res_overflow(res_overflow), .err_underflow(err_underflow), .err_full(err_full), .busy(busy)
  );

  // Behavioural stack ALU: combinational result, stack updated on the clock edge.
  always_comb begin
    alu_top      = (sp > 0) ? int'(stk[sp-1]) : 0;
    alu_nxt      = (sp > 1) ? int'(stk[sp-2]) : 0;
    alu_full     = 0;
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      ADD: alu_full = alu_top + alu_nxt;
      MUL: alu_full = alu_top * alu_nxt;
      POP: alu_full = alu_top;
      default: alu_full = 0;
    endcase
    alu_result = N'(alu_full);
    if (alu_opcode == ADD || alu_opcode == MUL) alu_overflow = (alu_full > 127) || (alu_full < -128);
  end

  always @(posedge clk) begin
    if (alu_opcode == PUSH) begin
      n_push++;
      if (sp < N) begin
        stk[sp] <= alu_data;
        sp <= sp + 1;
      end
    end else if (alu_opcode == POP && sp > 0) begin
      sp <= sp - 1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (err_full) n_full++;
    if (err_underflow) n_uf++;
    if (res_valid) begin
      n_res++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e_mon = sb.pop_front();
        chk("res_data", res_data, e_mon.d);
        chk("res_overflow", res_overflow, e_mon.o);
        chk("res_err_underflow", err_underflow, e_mon.u);
      end
    end
  end

  function automatic bit ovf8(input int v);
    return (v > 127) || (v < -128);
  endfunction

  function automatic int wrap8(input int v);
    logic signed [N-1:0] t;
    t = N'(v);
    return int'(t);
  endfunction

  function automatic int expect_op(input bit mul, input int a, input int b);
    int full;
    bit neg;
    full = mul ? a * b : a + b;
    neg  = mul ? ((a < 0) ^ (b < 0)) : (a < 0);
    if (SAT && ovf8(full)) return neg ? -128 : 127;
    return wrap8(full);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input bit is_op, input bit op, input int val, input bit last, output int cyc);
    tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_value = N'(val); tok_last = last;
    tick();
    cyc = 1;
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_op = 1'b0; tok_value = '0; tok_last = 1'b0;
    while (!tok_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("tok_ready_return", tok_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, tot, v1, n0, p0;
    // Reset state
    tick(); tick();
    chk("rst_opcode", alu_opcode, NOP);
    chk("rst_busy", busy, 0);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_errs", {err_full, err_underflow}, 0);
    // Flush: N POP/NOP pairs
    rst = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      #1;
      chk("flush_opcode", alu_opcode, (i % 2 == 0) ? POP : NOP);
      chk("flush_busy_ready", {busy, tok_ready}, 2'b10);
      tick();
    end
    chk("idle_ready", {busy, tok_ready}, 2'b01);
    chk("flush_alu_empty", sp, 0);

    // 3 4 + 5 *(last)
    v1 = expect_op(0, 3, 4);
    sb.push_back('{d: expect_op(1, v1, 5), o: ovf8(3 + 4) | ovf8(v1 * 5), u: 1'b0});
    send(0, 0, 3, 0, c); tot = c;
    send(0, 0, 4, 0, c); tot += c;
    send(1, 0, 0, 0, c); tot += c;
    send(0, 0, 5, 0, c); tot += c;
    send(1, 1, 0, 1, c); tot += c;
    chk("expr1_cycles", tot, 24);
    chk("expr1_seen", sb.size(), 0);

    // 100 100 +(last): wraps or saturates
    sb.push_back('{d: expect_op(0, 100, 100), o: 1'b1, u: 1'b0});
    send(0, 0, 100, 0, c);
    send(0, 0, 100, 0, c);
    send(1, 0, 0, 1, c);
    chk("expr2_seen", sb.size(), 0);

    // 7 *(last): operator underflows, FINAL still pops 7
    n0 = n_uf;
    sb.push_back('{d: 7, o: 1'b0, u: 1'b0});
    send(0, 0, 7, 0, c);
    send(1, 1, 0, 1, c);
    chk("underflow_pulses", n_uf - n0, 1);
    chk("expr3_alu_empty", sp, 0);

    // Fill to depth N, 9th operand rejected
    n0 = n_full; p0 = n_push;
    for (int v = 1; v <= N; v++) send(0, 0, v, 0, c);
    chk("full_not_early", n_full - n0, 0);
    send(0, 0, 9, 0, c);
    chk("full_on_9th", n_full - n0, 1);
    chk("full_push_count", n_push - p0, N);
    chk("full_alu_depth", sp, N);
    sb.push_back('{d: expect_op(0, 7, 8), o: 1'b0, u: 1'b0});
    send(1, 0, 0, 1, c);
    chk("drain_cycles", c, 8 + 2 + 2 * (N - 2));
    chk("drain_alu_empty", sp, 0);

    // Lone operator with last on an empty stack: FINAL with depth 0
    n0 = n_uf;
    sb.push_back('{d: 0, o: 1'b0, u: 1'b1});
    send(1, 0, 0, 1, c);
    chk("empty_final_cycles", c, 2);
    chk("empty_final_uf_pulses", n_uf - n0, 2);

    // -100 2 *(last): sign of saturation from A xor B
    sb.push_back('{d: expect_op(1, -100, 2), o: 1'b1, u: 1'b0});
    send(0, 0, -100, 0, c);
    send(0, 0, 2, 0, c);
    send(1, 1, 0, 1, c);
    chk("expr_mul_seen", sb.size(), 0);

    // Reset in the middle of an operator sequence
    send(0, 0, 2, 0, c);
    send(0, 0, 3, 0, c);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 1'b0; tok_last = 1'b1;
    tick();
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_last = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_opcode", alu_opcode, NOP);
    chk("midrst_busy_ready", {busy, tok_ready}, 0);
    chk("midrst_res", {res_valid, res_overflow, err_full, err_underflow}, 0);
    chk("midrst_res_data", res_data, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reflush_opcode", alu_opcode, POP);
    c = 0;
    while (!tok_ready && c < 100) begin
      tick();
      c++;
    end
    chk("reflush_cycles", c, 2 * N);
    chk("reflush_alu_empty", sp, 0);
    sb.push_back('{d: expect_op(1, 2, 2), o: 1'b0, u: 1'b0});
    send(0, 0, 2, 0, c);
    send(0, 0, 2, 0, c);
    send(1, 1, 0, 1, c);
    tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("result_count", n_res, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
